// File: rtl/riscv_decode_pkg.sv
// Shared RISC-V decode definitions: opcodes, instruction format encoding and decoded-beat struct.
package riscv_decode_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FmtR   = 3'd0,
        FmtI   = 3'd1,
        FmtS   = 3'd2,
        FmtB   = 3'd3,
        FmtU   = 3'd4,
        FmtJ   = 3'd5,
        FmtUnk = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [11:0]     imm12;
        fmt_e            format;
        logic            illegal;
    } beat_t;

endpackage

// File: rtl/imm12_field_decode.sv
// Combinational instruction format classifier and raw 12-bit immediate assembler.
// Honours ILLEGAL_OPCODE_DETECT_EN (flags unknown opcodes / non-32-bit encodings).
module imm12_field_decode
    import riscv_decode_pkg::*;
(
    input  logic [31:0] instr,
    output fmt_e        format,
    output logic [11:0] imm12,
    output logic        illegal
);

    fmt_e fmt_raw;
    logic unused_instr;

    // rs1/funct3 bits never contribute to the immediate
    assign unused_instr = ^instr[19:12];

    always_comb begin
        fmt_raw = FmtUnk;
        case (instr[6:0])
            OP:                          fmt_raw = FmtR;
            OP_IMM, LOAD, JALR, SYSTEM:  fmt_raw = FmtI;
            STORE:                       fmt_raw = FmtS;
            BRANCH:                      fmt_raw = FmtB;
            LUI, AUIPC:                  fmt_raw = FmtU;
            JAL:                         fmt_raw = FmtJ;
            default:                     fmt_raw = FmtUnk;
        endcase
    end

    always_comb begin
        format  = fmt_raw;
        illegal = 1'b0;
`ifdef ILLEGAL_OPCODE_DETECT_EN
        if (fmt_raw == FmtUnk || instr[1:0] != 2'b11) begin
            illegal = 1'b1;
            format  = FmtUnk;
        end
`endif
        case (format)
            FmtI:    imm12 = instr[31:20];
            FmtS:    imm12 = {instr[31:25], instr[11:7]};
            FmtB:    imm12 = {instr[31], instr[7], instr[30:25], instr[11:8]};
            default: imm12 = 12'h000;
        endcase
    end

endmodule

// File: rtl/if_id_imm_decode.sv
// Fetch-to-decode stage: 2-entry skid buffer holding pre-decoded beats, registered outputs.
// Build option: ILLEGAL_OPCODE_DETECT_EN adds the Out_Illegal port.
module if_id_imm_decode
    import riscv_decode_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            In_Valid,
    output logic            In_Ready,
    input  logic [31:0]     In_Instr,
    input  logic [PC_W-1:0] In_PC,
    input  logic            Flush,
    output logic            Out_Valid,
    input  logic            Out_Ready,
    output logic [PC_W-1:0] Out_PC,
    output logic [6:0]      Out_Opcode,
    output logic [4:0]      Out_Rd,
    output logic [4:0]      Out_Rs1,
    output logic [4:0]      Out_Rs2,
    output logic [2:0]      Out_Funct3,
    output logic [6:0]      Out_Funct7,
    output logic [11:0]     Out_Imm12,
`ifdef ILLEGAL_OPCODE_DETECT_EN
    output logic [2:0]      Out_Format,
    output logic            Out_Illegal
`else
    output logic [2:0]      Out_Format
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e state_q, state_d;
    beat_t  main_q, main_d, skid_q, skid_d;
    beat_t  dec;
    fmt_e   dec_format;
    logic [11:0] dec_imm12;
    logic   dec_illegal;
    logic   acc, pop;

    imm12_field_decode u_imm12_field_decode (
        .instr   (In_Instr),
        .format  (dec_format),
        .imm12   (dec_imm12),
        .illegal (dec_illegal)
    );

    always_comb begin
        dec         = '0;
        dec.pc      = XLEN'(In_PC);
        dec.opcode  = In_Instr[6:0];
        dec.rd      = In_Instr[11:7];
        dec.funct3  = In_Instr[14:12];
        dec.rs1     = In_Instr[19:15];
        dec.rs2     = In_Instr[24:20];
        dec.funct7  = In_Instr[31:25];
        dec.imm12   = dec_imm12;
        dec.format  = dec_format;
        dec.illegal = dec_illegal;
    end

    // Ready comes from state only, so no combinational path from Out_Ready to In_Ready
    assign In_Ready  = (state_q != StFull);
    assign Out_Valid = (state_q != StEmpty);
    assign acc       = In_Valid & In_Ready;
    assign pop       = Out_Valid & Out_Ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (Flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (acc) begin
                        main_d  = dec;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (acc && pop) begin
                        main_d = dec;
                    end else if (acc) begin
                        skid_d  = dec;
                        state_d = StFull;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign Out_PC     = PC_W'(main_q.pc);
    assign Out_Opcode = main_q.opcode;
    assign Out_Rd     = main_q.rd;
    assign Out_Rs1    = main_q.rs1;
    assign Out_Rs2    = main_q.rs2;
    assign Out_Funct3 = main_q.funct3;
    assign Out_Funct7 = main_q.funct7;
    assign Out_Imm12  = main_q.imm12;
    assign Out_Format = main_q.format;
`ifdef ILLEGAL_OPCODE_DETECT_EN
    assign Out_Illegal = main_q.illegal;
`else
    logic unused_illegal;
    assign unused_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_if_id_imm_decode.sv
// Scoreboard bench for if_id_imm_decode: directed test-plan beats followed by random traffic.
module tb_if_id_imm_decode;

    localparam int unsigned PC_W = 32;

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] imm12;
        logic [2:0]  format;
        logic        illegal;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            In_Valid, In_Ready, Flush, Out_Valid, Out_Ready;
    logic [31:0]     In_Instr;
    logic [PC_W-1:0] In_PC, Out_PC;
    logic [6:0]      Out_Opcode, Out_Funct7;
    logic [4:0]      Out_Rd, Out_Rs1, Out_Rs2;
    logic [2:0]      Out_Funct3, Out_Format;
    logic [11:0]     Out_Imm12;
    logic            Out_Illegal;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    if_id_imm_decode #(.PC_W(PC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .In_Instr   (In_Instr),
        .In_PC      (In_PC),
        .Flush      (Flush),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Out_PC     (Out_PC),
        .Out_Opcode (Out_Opcode),
        .Out_Rd     (Out_Rd),
        .Out_Rs1    (Out_Rs1),
        .Out_Rs2    (Out_Rs2),
        .Out_Funct3 (Out_Funct3),
        .Out_Funct7 (Out_Funct7),
        .Out_Imm12  (Out_Imm12),
`ifdef ILLEGAL_OPCODE_DETECT_EN
        .Out_Format (Out_Format),
        .Out_Illegal(Out_Illegal)
`else
        .Out_Format (Out_Format)
`endif
    );

`ifndef ILLEGAL_OPCODE_DETECT_EN
    assign Out_Illegal = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference: format table and immediate layouts straight from the ISA field rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        e.pc = pc;
        e.opcode = ins[6:0];
        e.rd = ins[11:7];
        e.funct3 = ins[14:12];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.funct7 = ins[31:25];
        e.imm12 = 12'h000;
        e.illegal = 1'b0;
        case (ins[6:0])
            7'b0110011: e.format = 3'd0;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                e.format = 3'd1;
                e.imm12 = ins[31:20];
            end
            7'b0100011: begin
                e.format = 3'd2;
                e.imm12 = {ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                e.format = 3'd3;
                e.imm12 = {ins[31], ins[7], ins[30:25], ins[11:8]};
            end
            7'b0110111, 7'b0010111: e.format = 3'd4;
            7'b1101111: e.format = 3'd5;
            default: e.format = 3'd7;
        endcase
`ifdef ILLEGAL_OPCODE_DETECT_EN
        if (e.format == 3'd7 || ins[1:0] != 2'b11) begin
            e.illegal = 1'b1;
            e.format = 3'd7;
            e.imm12 = 12'h000;
        end
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares the presented beat against the queue head every cycle it is valid
    always @(negedge clk) begin
        if (!reset) begin
            check("out_valid", 64'(Out_Valid), 64'(exp_q.size() != 0));
            check("in_ready", 64'(In_Ready), 64'(exp_q.size() < 2));
            if (Out_Valid && exp_q.size() != 0) begin
                check("out_pc", 64'(Out_PC), 64'(exp_q[0].pc));
                check("out_opcode", 64'(Out_Opcode), 64'(exp_q[0].opcode));
                check("out_rd", 64'(Out_Rd), 64'(exp_q[0].rd));
                check("out_rs1", 64'(Out_Rs1), 64'(exp_q[0].rs1));
                check("out_rs2", 64'(Out_Rs2), 64'(exp_q[0].rs2));
                check("out_funct3", 64'(Out_Funct3), 64'(exp_q[0].funct3));
                check("out_funct7", 64'(Out_Funct7), 64'(exp_q[0].funct7));
                check("out_imm12", 64'(Out_Imm12), 64'(exp_q[0].imm12));
                check("out_format", 64'(Out_Format), 64'(exp_q[0].format));
                check("out_illegal", 64'(Out_Illegal), 64'(exp_q[0].illegal));
                if (Out_Ready) void'(exp_q.pop_front());
            end
        end
    end

    // Drive one cycle from posedge+1; after the monitor has run, record what the edge will do
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        In_Valid = v;
        In_Instr = ins;
        In_PC = pc;
        Out_Ready = ordy;
        Flush = fl;
        @(negedge clk);
        #1;
        if (!reset) begin
            if (Flush) exp_q.delete();
            else if (In_Valid && In_Ready) exp_q.push_back(model(In_Instr, In_PC));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, 64'(Out_Valid), 64'd0);
        check({tag, "_in_ready"}, 64'(In_Ready), 64'd1);
        check({tag, "_fields"}, {Out_PC, Out_Opcode, Out_Rd, Out_Rs1, Out_Rs2, Out_Funct3},
              64'd0);
        check({tag, "_fields2"}, {Out_Funct7, Out_Imm12, Out_Format, Out_Illegal}, 64'd0);
    endtask

    logic [6:0] ops [10] = '{7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111,
                             7'b0010111, 7'b1101111, 7'b1100111, 7'b0110011, 7'b1110011};

    initial begin
        logic [31:0] ins;
        reset = 1'b1;
        In_Valid = 1'b1;
        In_Instr = 32'h06400093;
        In_PC = 32'h0000_0040;
        Out_Ready = 1'b1;
        Flush = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_hold");
        reset = 1'b0;

        // Test-plan beats: ADDI, SW, BEQ, illegal opcode
        cycle(1'b1, 32'h06400093, 32'h100, 1'b1, 1'b0);
        cycle(1'b1, 32'h00112623, 32'h104, 1'b1, 1'b0);
        cycle(1'b1, 32'hFE000EE3, 32'h108, 1'b1, 1'b0);
        cycle(1'b1, 32'h12345680, 32'h10C, 1'b1, 1'b0);
        cycle(1'b1, 32'h00000013 | 32'h2, 32'h110, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Backpressure: three beats against a stalled consumer, then drain
        cycle(1'b1, 32'h00500113, 32'h200, 1'b0, 1'b0);
        cycle(1'b1, 32'h00A00193, 32'h204, 1'b0, 1'b0);
        cycle(1'b1, 32'h00F00213, 32'h208, 1'b0, 1'b0);
        cycle(1'b1, 32'h00F00213, 32'h208, 1'b0, 1'b0);
        cycle(1'b1, 32'h00F00213, 32'h208, 1'b1, 1'b0);
        cycle(1'b1, 32'h00F00213, 32'h208, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while full with a beat offered
        cycle(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 32'h304, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300093, 32'h308, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset while full
        cycle(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 32'h404, 1'b0, 1'b0);
        check("full_before_reset", 64'(In_Ready), 64'd0);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            ins = $urandom();
            if ($urandom_range(0, 11) < 10) ins[6:0] = ops[$urandom_range(0, 9)];
            cycle($urandom_range(0, 3) != 0, ins, $urandom(), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < 3);
        end

        repeat (4) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drained", 64'(Out_Valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
